// File: rtl/ex_muldiv_unit_pkg.sv
// Shared EX-stage encodings: mul/div opcodes and muldiv FSM states.
// No ports; imported by the muldiv unit and its step datapath.
package ex_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

endpackage

// File: rtl/ex_muldiv_unit_step.sv
// One combinational iteration: MSB-first shift-add (mode 0) or restoring
// divide step (mode 1). Ports: mode_i, acc_i/acc_o, opnd_i, bit_i.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               mode_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH:0]     opnd_i,
    input  logic               bit_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem;

    always_comb begin
        // Partial remainder with the next dividend bit shifted in.
        trial = {acc_i[2*WIDTH-1:WIDTH], bit_i};
        ge    = (trial >= opnd_i);
        // The true result is < divisor < 2^WIDTH, so low bits suffice.
        rem   = ge ? (trial[WIDTH-1:0] - opnd_i[WIDTH-1:0])
                   : trial[WIDTH-1:0];
        if (mode_i) begin
            acc_o = {rem, acc_i[WIDTH-2:0], ge};
        end else begin
            acc_o = (acc_i << 1)
                  + (bit_i ? {{(WIDTH-1){1'b0}}, opnd_i}
                           : {(2*WIDTH){1'b0}});
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative mul/div unit owning HI/LO; stalls upstream while busy.
// Ports: clk, Reset, Start, Op, Rs_data, Rt_data, Read_req, Flush -> Hi_out, Lo_out, Busy, Done, Stall.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] Rs_data,
    input  logic [WIDTH-1:0] Rt_data,
    input  logic             Read_req,
    input  logic             Flush,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     b_q, b_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [CW-1:0]      idx;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;

    // WIDTH+1-bit magnitude so that |most negative| is exact.
    function automatic logic [WIDTH:0] mag(
        input logic [WIDTH-1:0] x,
        input logic             neg
    );
        logic [WIDTH:0] e;
        e = {neg, x};
        return neg ? -e : e;
    endfunction

    assign idx = CW'(WIDTH - 1) - cnt_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_i (div_q),
        .acc_i  (acc_q),
        .opnd_i (div_q ? b_q : a_q),
        .bit_i  (div_q ? a_q[idx] : b_q[idx]),
        .acc_o  (step_acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        sgn_op = (Op == MD_MULT) || (Op == MD_DIV);
        a_neg  = sgn_op & Rs_data[WIDTH-1];
        b_neg  = sgn_op & Rt_data[WIDTH-1];

        prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    case (Op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            a_d     = mag(Rs_data, a_neg);
                            b_d     = mag(Rt_data, b_neg);
                            sa_d    = a_neg;
                            sb_d    = b_neg;
                            acc_d   = '0;
                            cnt_d   = '0;
                            div_d   = (Op == MD_DIV) || (Op == MD_DIVU);
                            state_d = div_d ? DIV : MUL;
                            // Divide by zero: preload the result, skip iterating.
                            if (div_d && (Rt_data == '0)) begin
                                acc_d   = {Rs_data, {WIDTH{1'b1}}};
                                sa_d    = 1'b0;
                                sb_d    = 1'b0;
                                state_d = FIN;
                            end
                        end
                        MD_MTHI: hi_d = Rs_data;
                        MD_MTLO: lo_d = Rs_data;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = div_q ? quo : prod[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over every write, including MTHI/MTLO and FIN.
        if (Flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign Hi_out = hi_q;
    assign Lo_out = lo_q;
    assign Busy   = (state_q != IDLE);
    assign Done   = done_q;
    assign Stall  = Busy & (Start | Read_req);

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit on the EX side of the pipeline. It consumes the operand values and decoded mul/div opcode presented at the ID/EX register outputs and owns the architectural HI/LO registers. It raises Stall so the hazard logic can hold IF/ID and ID/EX while an operation is in flight. Flush aborts an in-flight operation, for example on an exception.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each; the iteration count equals WIDTH.

Ports:
clk  in  1  pipeline clock; all state updates on the falling edge, like the pipeline registers
Reset  in  1  synchronous, active-high reset
Start  in  1  operation request; valid with Op, Rs_data and Rt_data
Op  in  3  operation code from the shared package
Rs_data  in  WIDTH  operand A (dividend / multiplicand)
Rt_data  in  WIDTH  operand B (divisor / multiplier)
Read_req  in  1  EX holds an MFHI/MFLO
Flush  in  1  abort the in-flight operation
Hi_out  out  WIDTH  HI register
Lo_out  out  WIDTH  LO register
Busy  out  1  operation in flight
Done  out  1  one-cycle pulse when HI/LO are updated by a mul/div
Stall  out  1  hold upstream stages; equals Busy & (Start | Read_req)

Behaviour:
- Reset values: Hi_out=0, Lo_out=0, Busy=0, Done=0, state=IDLE, counter=0. Reset overrides every other input.
- States are IDLE, MUL, DIV and FIN. Busy=1 in MUL, DIV and FIN.
- IDLE with Start:
  - MULT/MULTU or DIV/DIVU:
    - latch |A| and |B|, treating operands as two's complement for MULT/DIV only;
    - latch the sign flags;
    - clear the 64-bit accumulator and the counter;
    - go to MUL or DIV.
  - MTHI/MTLO: write Rs_data to HI or LO at this edge. Busy stays 0 and Done stays 0.
  - MD_NONE or Start=0: remain in IDLE.
- MUL: one shift-add step per edge. After WIDTH steps, go to FIN.
- DIV: one restoring step per edge, quotient in the low half and remainder in the high half. After WIDTH steps, go to FIN.
- DIV/DIVU with Rt_data=0: skip DIV and go directly to FIN with HI=Rs_data and LO={WIDTH{1}}.
- FIN edge:
  - apply sign correction:
    - product is negated if sa^sb;
    - quotient is negated if sa^sb;
    - remainder is negated if sa.
  - write HI/LO (HI = product high word or remainder; LO = product low word or quotient);
  - Done=1 for exactly one cycle;
  - return to IDLE.
- Latency: Start sampled at edge n gives HI/LO valid and Done=1 after edge n+WIDTH+1 (n+33 by default). Busy is 1 from edge n through edge n+WIDTH+1. Divide-by-zero gives HI/LO valid after edge n+1.
- Start while Busy: ignored, not queued. Upstream is held by Stall and re-presents the request.
- Read_req while Busy: Stall=1. After Done the stale value is never read.
- Flush: at the next edge return to IDLE. HI/LO keep their pre-operation values, Done=0, Busy=0.
- Flush in IDLE coincident with Start: Start is ignored and no MTHI/MTLO write occurs.
- Flush during FIN: the abort wins and there is no HI/LO write.
- Overflow cases:
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - MULT 0x80000000 * 0x80000000 gives HI=0x40000000, LO=0.
  - Use WIDTH+1-bit magnitudes internally so |0x80000000| is exact.

Decomposition:
- Shared package ex_pkg holds:
  - op localparams MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6;
  - state encodings IDLE=0, MUL=1, DIV=2, FIN=3.
- One natural sub-module: muldiv_step, a combinational single-iteration datapath for the shift-add and restore-subtract steps, selected by a mode bit. The FSM, counter, sign handling and HI/LO registers stay in ex_muldiv_unit.

Test Plan:
- Reset mid-MUL (Reset at cycle 10 after Start) -> next edge Busy=0, Done=0, Hi_out=Lo_out=0, state IDLE.
- MULTU Rs=0xFFFFFFFF, Rt=0xFFFFFFFF -> after 33 edges Done pulses once; Hi=0xFFFFFFFE, Lo=0x00000001; Busy=1 for exactly 33 cycles.
- MULT Rs=0xFFFFFFFD (-3), Rt=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. DIV Rs=-7, Rt=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU Rs=0x12345678, Rt=0 -> Done after 2 edges, Hi=0x12345678, Lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MTHI 0xA5A5A5A5 then MULT 3*4 with Read_req held from cycle 5 -> Hi reads 0xA5A5A5A5 before the MULT; Stall=1 until Done; then Hi=0, Lo=12. A second Start during Busy changes nothing.
- MULT 5*6, Flush at cycle 20 -> Busy=0 next edge, no Done pulse, Hi/Lo keep their prior values; Flush coincident with MTLO in IDLE -> Lo unchanged.
